// File: rtl/mc_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB control sequencer with req/ack memory handshakes,
// bus timeout, halt state and optional performance counters (SEQ_PERF_CNT_EN).
module mc_sequencer #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_halt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_wre,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_wre,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    sIf   = 3'd0,
    sId   = 3'd1,
    sExe  = 3'd2,
    sMem  = 3'd3,
    sWb   = 3'd4,
    sHalt = 3'd7
  } state_t;

  localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t        state, stateNext;
  logic [WW-1:0] waitCnt, waitNext;
  logic          busErr, busErrSet;
  logic          imemReq, irWre, dmemReq, dmemWe, regWe, pcWre;
  logic          timeoutHit;

  // Last permitted request cycle without an ack; never reached when WAIT_MAX is 0.
  assign timeoutHit = (WAIT_MAX > 0) && (waitCnt == WW'(WAIT_MAX - 1));

  always_comb begin
    stateNext = state;
    waitNext  = '0;
    busErrSet = 1'b0;
    imemReq   = 1'b0;
    irWre     = 1'b0;
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    regWe     = 1'b0;
    pcWre     = 1'b0;
    case (state)
      sIf: begin
        imemReq = 1'b1;
        if (imem_ack) begin
          irWre     = 1'b1;
          stateNext = sId;
        end else if (timeoutHit) begin
          busErrSet = 1'b1;
          stateNext = sHalt;
        end else if (WAIT_MAX > 0) begin
          waitNext = waitCnt + WW'(1);
        end
      end
      sId: begin
        if (is_halt) begin
          stateNext = sHalt;
        end else if (is_jal) begin
          regWe     = 1'b1;
          pcWre     = 1'b1;
          stateNext = sIf;
        end else begin
          stateNext = sExe;
        end
      end
      sExe: begin
        if (is_branch) begin
          pcWre     = 1'b1;
          stateNext = sIf;
        end else if (is_load || is_store) begin
          stateNext = sMem;
        end else begin
          stateNext = sWb;
        end
      end
      sMem: begin
        dmemReq = 1'b1;
        dmemWe  = is_store;
        if (dmem_ack) begin
          if (is_load) begin
            stateNext = sWb;
          end else begin
            pcWre     = 1'b1;
            stateNext = sIf;
          end
        end else if (timeoutHit) begin
          busErrSet = 1'b1;
          stateNext = sHalt;
        end else if (WAIT_MAX > 0) begin
          waitNext = waitCnt + WW'(1);
        end
      end
      sWb: begin
        regWe     = 1'b1;
        pcWre     = 1'b1;
        stateNext = sIf;
      end
      sHalt: stateNext = sHalt;
      default: stateNext = sIf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= sIf;
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
      if (busErrSet) busErr <= 1'b1;
    end
  end

  // Every output is held low while reset is asserted, including in-flight requests.
  always_comb begin
    imem_req = rst & imemReq;
    ir_wre   = rst & irWre;
    dmem_req = rst & dmemReq;
    dmem_we  = rst & dmemWe;
    reg_we   = rst & regWe;
    pc_wre   = rst & pcWre;
    bus_err  = rst & busErr;
    state_o  = rst ? state : 3'd0;
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt, instretCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCnt   <= '0;
      instretCnt <= '0;
    end else begin
      if (state != sHalt) cycleCnt <= cycleCnt + CNT_W'(1);
      if (pcWre) instretCnt <= instretCnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycleCnt;
  assign instret_cnt = instretCnt;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares. Counter expectations follow SEQ_PERF_CNT_EN.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jal = 1'b0, is_halt = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, ir_wre, dmem_req, dmem_we, reg_we, pc_wre, bus_err;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_sequencer #(.WAIT_MAX(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_halt(is_halt),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_wre(ir_wre), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_wre(pc_wre), .bus_err(bus_err), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  en;   // {imem_req, ir_wre, dmem_req, dmem_we, reg_we, pc_wre, bus_err}
    logic [31:0] cyc;
    logic [31:0] ret;
  } snap_t;

  snap_t expQ[$];
  int    tagQ[$];
  int    checks = 0;
  int    failures = 0;
  int    step = 0;
  int    tag = 0;
  int    expCycle = 0;
  int    expInstret = 0;

  // class vector {halt, jal, branch, load, store}
  localparam logic [4:0] C_ALU = 5'b00000, C_ST = 5'b00001, C_LD = 5'b00010,
                         C_BR = 5'b00100, C_JAL = 5'b01000, C_HJ = 5'b11000;
  localparam logic [6:0] E_NONE = 7'b0000000, E_FETCH = 7'b1000000, E_FIR = 7'b1100000,
                         E_WB = 7'b0000110, E_BR = 7'b0000010, E_LDM = 7'b0010000,
                         E_STM = 7'b0011010, E_ERR = 7'b0000001;

  task automatic chk_now(input string what, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: state=%0d imem_req=%b ir_wre=%b dmem_req=%b dmem_we=%b reg_we=%b pc_wre=%b bus_err=%b cyc=%0d ret=%0d",
               what, state_o, imem_req, ir_wre, dmem_req, dmem_we, reg_we, pc_wre, bus_err,
               cycle_cnt, instret_cnt);
    end
  endtask

  task automatic cyc(input bit r, input logic [4:0] cls, input bit ia, input bit da,
                     input logic [2:0] es, input logic [6:0] een);
    snap_t e;
    @(posedge clk);
    #1;
    rst = r;
    {is_halt, is_jal, is_branch, is_load, is_store} = cls;
    imem_ack = ia;
    dmem_ack = da;
    if (!r) begin
      expCycle   = 0;
      expInstret = 0;
    end
    e.st = r ? es : 3'd0;
    e.en = r ? een : 7'd0;
`ifdef SEQ_PERF_CNT_EN
    e.cyc = 32'(expCycle);
    e.ret = 32'(expInstret);
`else
    e.cyc = '0;
    e.ret = '0;
`endif
    expQ.push_back(e);
    tagQ.push_back(tag);
    if (r) begin
      if (es != 3'd7) expCycle++;
      if (een[1]) expInstret++;
    end
  endtask

  always @(negedge clk) begin
    snap_t e, a;
    int t;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      a = {state_o, imem_req, ir_wre, dmem_req, dmem_we, reg_we, pc_wre, bus_err,
           cycle_cnt, instret_cnt};
      step++;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scen%0d step%0d: state got=%0d exp=%0d en got=%b exp=%b cyc got=%0d exp=%0d ret got=%0d exp=%0d",
                 t, step, a.st, e.st, a.en, e.en, a.cyc, e.cyc, a.ret, e.ret);
      end
    end
  end

  initial begin
    tag = 1;  // reset with acks high: everything gated
    repeat (2) cyc(0, C_ALU, 1, 1, 0, E_NONE);

    tag = 2;  // ALU, acks held
    cyc(1, C_ALU, 1, 1, 0, E_FIR);
    cyc(1, C_ALU, 1, 1, 1, E_NONE);
    cyc(1, C_ALU, 1, 1, 2, E_NONE);
    cyc(1, C_ALU, 1, 1, 4, E_WB);

    tag = 3;  // load, dmem_ack on 4th MEM cycle
    cyc(1, C_LD, 1, 0, 0, E_FIR);
    cyc(1, C_LD, 0, 0, 1, E_NONE);
    cyc(1, C_LD, 0, 0, 2, E_NONE);
    repeat (3) cyc(1, C_LD, 0, 0, 3, E_LDM);
    cyc(1, C_LD, 0, 1, 3, E_LDM);
    cyc(1, C_LD, 0, 0, 4, E_WB);

    tag = 4;  // store, immediate acks
    cyc(1, C_ST, 1, 1, 0, E_FIR);
    cyc(1, C_ST, 1, 1, 1, E_NONE);
    cyc(1, C_ST, 1, 1, 2, E_NONE);
    cyc(1, C_ST, 1, 1, 3, E_STM);

    tag = 5;  // branch back-to-back
    cyc(1, C_BR, 1, 1, 0, E_FIR);
    cyc(1, C_BR, 1, 1, 1, E_NONE);
    cyc(1, C_BR, 1, 1, 2, E_BR);

    tag = 6;  // jal
    cyc(1, C_JAL, 1, 0, 0, E_FIR);
    cyc(1, C_JAL, 1, 0, 1, E_WB);

    tag = 7;  // fetch ack on the 8th request cycle: no error
    repeat (7) cyc(1, C_ALU, 0, 0, 0, E_FETCH);
    cyc(1, C_ALU, 1, 0, 0, E_FIR);
    cyc(1, C_ALU, 0, 0, 1, E_NONE);
    cyc(1, C_ALU, 0, 0, 2, E_NONE);
    cyc(1, C_ALU, 0, 0, 4, E_WB);

    tag = 8;  // fetch timeout, late acks ignored in HALT
    repeat (8) cyc(1, C_ALU, 0, 0, 0, E_FETCH);
    cyc(1, C_ALU, 1, 1, 7, E_ERR);
    #1;
    chk_now("expired fetch wait", bus_err === 1'b1 && state_o === 3'd7 &&
                                  imem_req === 1'b0 && ir_wre === 1'b0);
    repeat (2) cyc(1, C_ALU, 1, 1, 7, E_ERR);

    tag = 9;  // asynchronous reset out of HALT
    cyc(0, C_ALU, 0, 0, 0, E_NONE);
    #1;
    chk_now("reset state", state_o === 3'd0 && bus_err === 1'b0 && imem_req === 1'b0 &&
                           ir_wre === 1'b0 && dmem_req === 1'b0 && dmem_we === 1'b0 &&
                           reg_we === 1'b0 && pc_wre === 1'b0 &&
                           cycle_cnt === 32'd0 && instret_cnt === 32'd0);

    tag = 10; // data-memory timeout on a load
    cyc(1, C_LD, 1, 0, 0, E_FIR);
    cyc(1, C_LD, 0, 0, 1, E_NONE);
    cyc(1, C_LD, 0, 0, 2, E_NONE);
    repeat (8) cyc(1, C_LD, 0, 0, 3, E_LDM);
    repeat (2) cyc(1, C_LD, 0, 1, 7, E_ERR);

    tag = 11; // reset, then halt with jal in ID
    cyc(0, C_ALU, 0, 0, 0, E_NONE);
    cyc(1, C_HJ, 1, 0, 0, E_FIR);
    cyc(1, C_HJ, 1, 0, 1, E_NONE);
    repeat (3) cyc(1, C_HJ, 1, 1, 7, E_NONE);
    cyc(0, C_HJ, 1, 1, 0, E_NONE);

    tag = 12; // ALU after release, then idle fetch
    cyc(1, C_ALU, 1, 1, 0, E_FIR);
    cyc(1, C_ALU, 1, 1, 1, E_NONE);
    cyc(1, C_ALU, 1, 1, 2, E_NONE);
    cyc(1, C_ALU, 1, 1, 4, E_WB);
    cyc(1, C_ALU, 0, 0, 0, E_FETCH);

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Parametrised multi-cycle control sequencer for the single-issue MIPS-style core. It replaces the fixed-phase CU state machine and drives the PC, IR, register-file and memory write enables through the states IF/ID/EXE/MEM/WB. Instruction-memory and data-memory accesses use a req/ack handshake, so variable-latency memories, including block RAM, are supported. It adds a bus-timeout error, a halt state and performance counters. Instruction-class decode stays outside the block and is sourced from IR.

Parameters:
WAIT_MAX, 8, maximum request cycles per memory access before timeout; 0 disables the timeout.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-low
is_load  input  1  decoded class: load word (stable from ID to end of instruction)
is_store  input  1  decoded class: store word
is_branch  input  1  decoded class: conditional branch (taken/not-taken handled by PC mux)
is_jal  input  1  decoded class: jump-and-link / jump
is_halt  input  1  decoded class: halt
imem_ack  input  1  instruction memory data valid
dmem_ack  input  1  data memory access complete
imem_req  output  1  instruction fetch request
ir_wre  output  1  IR load enable
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (qualifies dmem_req)
reg_we  output  1  register-file write enable
pc_wre  output  1  PC update enable
bus_err  output  1  sticky timeout flag
state_o  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=7
cycle_cnt  output  CNT_W  non-halted cycle count
instret_cnt  output  CNT_W  retired instruction count

Behaviour:
- Reset (rst=0, asynchronous): state=IF, wait_cnt=0, bus_err=0, counters=0. All outputs are forced to 0 while rst=0. imem_req rises in the first cycle after release.
- All outputs are combinational from the registered state, the class inputs and the acks. There is no added latency.
- IF: imem_req=1. When imem_ack=1: ir_wre=1 and next state is ID. Otherwise stay in IF.
- ID (class priority halt > jal > branch > load > store):
  - halt: go to HALT; pc_wre=0.
  - jal: reg_we=1, pc_wre=1; go to IF.
  - otherwise: go to EXE.
- EXE:
  - branch: pc_wre=1; go to IF.
  - load or store: go to MEM.
  - otherwise (ALU op): go to WB.
- MEM: dmem_req=1; dmem_we=is_store.
  - On dmem_ack with a store: pc_wre=1; go to IF.
  - On dmem_ack with a load: go to WB.
  - Without dmem_ack: stay in MEM.
- WB: reg_we=1, pc_wre=1; go to IF.
- HALT: all enables 0. HALT is left only by reset.
- Cycle counts with zero-wait memories: jal 2, branch 3, ALU 4, store 4, load 5.
- Timeout (WAIT_MAX>0):
  - wait_cnt increments each IF/MEM cycle with the request high and no ack; it clears on ack or on a state change.
  - If wait_cnt==WAIT_MAX-1 and there is still no ack, set bus_err=1 and go to HALT at the next edge.
  - An ack is therefore accepted up to and including the WAIT_MAX-th request cycle.
- An ack received outside its matching request state is ignored.
- Counters:
  - cycle_cnt increments every cycle with state!=HALT.
  - instret_cnt increments on every cycle with pc_wre=1.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-access: the request drops immediately. There is no partial write: dmem_we is forced to 0 with rst=0.

Optional Feature:
Macro SEQ_PERF_CNT_EN.
- Defined: cycle_cnt and instret_cnt are implemented as above.
- Undefined: no counter registers; both outputs are tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then ALU op with imem_ack and dmem_ack held 1 -> state_o sequence 0,1,2,4,0; ir_wre pulses in cycle 1; reg_we and pc_wre pulse together in cycle 4; instret_cnt=1, cycle_cnt=4.
- Load with dmem_ack delayed 3 cycles (WAIT_MAX=8) -> MEM held 4 cycles, dmem_we=0, then WB with reg_we=1; total 8 cycles.
- Store then branch back-to-back, acks immediate -> store: dmem_req=dmem_we=1 for 1 cycle, pc_wre in MEM, reg_we never asserted. Branch: pc_wre in EXE. Totals 4 and 3 cycles; instret_cnt=2.
- imem_ack never asserted, WAIT_MAX=8 -> imem_req high for 8 cycles, bus_err=1 and state_o=7 after the 8th edge; cycle_cnt frozen at 8. With an ack on the 8th request cycle instead -> no error, state goes to ID.
- is_halt with is_jal both asserted in ID -> HALT, reg_we=0, pc_wre=0. Later rst pulse low mid-cycle -> immediate outputs 0, state_o=0, counters 0, bus_err 0.
- Build without SEQ_PERF_CNT_EN, rerun the first scenario -> identical control waveforms; cycle_cnt=instret_cnt=0 throughout.
